// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module      : if_stage
// Description : Instruction-fetch stage for the LEGv8 single-cycle core.
//               Holds the PC, fetches 32-bit instructions over a req/ack
//               handshake, presents instr/op_code to control and datapath,
//               and advances the PC (sequential or branch) on retire.
//               Optional performance counters are enabled by defining the
//               macro IF_PERF_CNT_EN (adds retired_cnt and stall_cnt).
// Revision    : 1.0 - initial release
// ============================================================================
module if_stage #(
  parameter int              PC_W     = 64,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  // instruction memory
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  // to control unit / datapath
  output logic [31:0]     instr,
  output logic [10:0]     op_code,
  output logic            instr_valid,
  output logic [PC_W-1:0] pc,
  // from datapath / control unit
  input  logic            retire,
  input  logic            pc_src,
  input  logic [PC_W-1:0] br_offset
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]     retired_cnt,
  output logic [31:0]     stall_cnt
`endif
);

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic [PC_W-1:0] w_pc_seq;
  logic [PC_W-1:0] w_pc_br;

  // Both PC candidates wrap modulo 2^PC_W; the shift drops the offset's top 2 bits.
  assign w_pc_seq = pc_q + PC_W'(4);
  assign w_pc_br  = pc_q + (br_offset << 2);

  // State, PC and instruction registers; reset overrides any ack/retire.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  // Next-state and handshake outputs; req/addr stay stable until ack.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    unique case (state_q)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        instr_valid = 1'b1;
        if (retire) begin
          pc_d    = pc_src ? w_pc_br : w_pc_seq;
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign instr     = instr_q;
  assign op_code   = instr_q[31:21];

`ifdef IF_PERF_CNT_EN
  logic [31:0] retired_cnt_q;
  logic [31:0] stall_cnt_q;

  // Free-running wrap-around counters for retired instructions and fetch stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      retired_cnt_q <= '0;
      stall_cnt_q   <= '0;
    end else begin
      if (state_q == ISSUE && retire) begin
        retired_cnt_q <= retired_cnt_q + 32'd1;
      end
      if (state_q == FETCH && !imem_ack) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign retired_cnt = retired_cnt_q;
  assign stall_cnt   = stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_stage
// Description : Directed self-checking bench for if_stage (PC_W=64,
//               RESET_PC=0). Counter checks compile in only when
//               IF_PERF_CNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_stage;

  localparam int PC_W = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;
  logic [31:0]     instr;
  logic [10:0]     op_code;
  logic            instr_valid;
  logic [PC_W-1:0] pc;
  logic            retire;
  logic            pc_src;
  logic [PC_W-1:0] br_offset;
`ifdef IF_PERF_CNT_EN
  logic [31:0]     retired_cnt;
  logic [31:0]     stall_cnt;
`endif

  int errors = 0;
  int checks = 0;

  if_stage #(.PC_W(PC_W), .RESET_PC(64'h0)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .op_code     (op_code),
    .instr_valid (instr_valid),
    .pc          (pc),
    .retire      (retire),
    .pc_src      (pc_src),
    .br_offset   (br_offset)
`ifdef IF_PERF_CNT_EN
    ,
    .retired_cnt (retired_cnt),
    .stall_cnt   (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge; inputs change and outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle zero-latency fetch of the given word.
  task automatic do_fetch(input logic [31:0] word);
    imem_ack   = 1'b1;
    imem_rdata = word;
    tick();
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
  endtask

  task automatic do_retire(input logic src, input logic [63:0] off);
    retire    = 1'b1;
    pc_src    = src;
    br_offset = off;
    tick();
    retire    = 1'b0;
    pc_src    = 1'b0;
    br_offset = '0;
  endtask

  initial begin
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0;
    retire = 1'b0; pc_src = 1'b0; br_offset = '0;
    tick(); tick();
    rst = 1'b0;

    // 1. reset state and first fetch
    check("rst_req",   imem_req,    1);
    check("rst_addr",  imem_addr,   0);
    check("rst_valid", instr_valid, 0);
    check("rst_op",    op_code,     0);
    do_fetch(32'h8B020020);
    check("t1_valid", instr_valid, 1);
    check("t1_op",    op_code,     11'h458);
    check("t1_instr", instr,       32'h8B020020);
    check("t1_req",   imem_req,    0);
    check("t1_pc",    pc,          0);

    // 2. sequential run, with wait states at pc=8 (4)
    do_retire(1'b0, 64'h0);
    check("t2_addr4", imem_addr, 4);
    check("t2_req4",  imem_req,  1);
    for (int i = 1; i < 4; i++) begin
      if (i == 2) begin
        for (int w = 0; w < 3; w++) begin
          retire = (w == 1);
          tick();
          check("t4_req",   imem_req,    1);
          check("t4_addr",  imem_addr,   8);
          check("t4_valid", instr_valid, 0);
        end
        retire = 1'b0;
`ifdef IF_PERF_CNT_EN
        check("t4_stall", stall_cnt, 3);
`endif
      end
      do_fetch(32'h91000000 + i);
      check("t2_valid", instr_valid, 1);
      check("t2_pc",    pc,          4 * i);
      check("t2_instr", instr,       32'h91000000 + i);
      do_retire(1'b0, 64'h0);
      check("t2_next",  imem_addr,   4 * (i + 1));
    end
`ifdef IF_PERF_CNT_EN
    check("t2_retired", retired_cnt, 4);
`endif

    // 3. branches: 0x10 -> 0x20 -> 0x14 -> 0x28
    do_fetch(32'hB4000080);
    do_retire(1'b1, 64'd4);
    check("t3_to20", imem_addr, 64'h20);
    do_fetch(32'hB4FFFFA0);
    do_retire(1'b1, 64'hFFFF_FFFF_FFFF_FFFD);
    check("t3_to14", imem_addr, 64'h14);
    do_fetch(32'hB40000A0);
    do_retire(1'b1, 64'd5);
    check("t3_to28", imem_addr, 64'h28);

    // branch back -11 words to the top of the address space
    do_fetch(32'hB4FFFEA0);
    do_retire(1'b1, 64'hFFFF_FFFF_FFFF_FFF5);
    check("t5_top", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);

    // 6. hold in ISSUE with noise on ack/pc_src
    do_fetch(32'hCAFE1234);
    for (int h = 0; h < 5; h++) begin
      imem_ack   = h[0];
      pc_src     = ~h[0];
      imem_rdata = 32'h1111_1111 * (h + 1);
      tick();
      check("t6_instr", instr,       32'hCAFE1234);
      check("t6_op",    op_code,     11'h657);
      check("t6_pc",    pc,          64'hFFFF_FFFF_FFFF_FFFC);
      check("t6_req",   imem_req,    0);
      check("t6_valid", instr_valid, 1);
    end
    imem_ack = 1'b0; pc_src = 1'b0; imem_rdata = '0;

    // 5. wrap, then reset colliding with an ack
    do_retire(1'b0, 64'h0);
    check("t5_wrap", imem_addr, 0);
    do_fetch(32'h8B020020);
    do_retire(1'b0, 64'h0);
    check("t5_pc4", imem_addr, 4);
    rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEADBEEF;
    tick();
    rst = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
    check("t5_instr", instr,       0);
    check("t5_pc",    pc,          0);
    check("t5_valid", instr_valid, 0);
    check("t5_req",   imem_req,    1);
`ifdef IF_PERF_CNT_EN
    check("t5_rcnt", retired_cnt, 0);
    check("t5_scnt", stall_cnt,   0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety net against a runaway simulation.
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
